// File: rtl/cpu_pkg.sv
// Shared definitions for cpu_pipelined: instruction encodings, ALU ops, pipeline-register types
// and the default program image. Pure definitions, no state, no backpressure.
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int PROG_WORDS = 32;
    localparam int PROG_AW    = 5;
    typedef logic [PROG_WORDS-1:0][31:0] prog_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
    } alu_op_t;

    typedef struct packed {
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
`ifdef CPU_PIPELINED_FWD_EN
        logic [4:0]  rs1;
        logic [4:0]  rs2;
`endif
        alu_op_t     alu_op;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
        logic        mem_re;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_we;
        logic        mem_re;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    function automatic prog_t default_prog();
        prog_t p;
        for (int i = 0; i < PROG_WORDS; i++) p[i] = NOP;
        p[0] = 32'h0050_0093;
        p[4] = 32'h0030_0113;
        p[8] = 32'h0020_81B3;
        return p;
    endfunction

    // For I-type the funct7 field is immediate bits, so it only qualifies the shifts.
    function automatic logic decode_alu(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic is_imm, output alu_op_t op);
        logic ok;
        op = ALU_ADD;
        ok = is_imm || (f7 == F7_BASE);
        case (f3)
            F3_ADD_SUB: begin
                if (!is_imm && f7 == F7_ALT) begin
                    op = ALU_SUB;
                    ok = 1'b1;
                end
            end
            F3_SLL:  begin op = ALU_SLL;  ok = (f7 == F7_BASE); end
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: begin
                op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                ok = (f7 == F7_BASE) || (f7 == F7_ALT);
            end
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cpu_pipelined_regfile.sv
// 32x32 register file: two async read ports with write-through, one write port on the rising edge.
// x0 reads as zero and ignores writes; synchronous active-high reset clears every register.
module cpu_pipelined_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_dat_o,
    output logic [31:0] rs2_dat_o,
    input  logic        we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_dat_i
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && rd_addr_i != 5'd0) begin
            registers[rd_addr_i] <= rd_dat_i;
        end
    end

    assign rs1_dat_o = (rs1_addr_i == 5'd0) ? 32'd0 :
                       (we_i && rd_addr_i == rs1_addr_i) ? rd_dat_i : registers[rs1_addr_i];
    assign rs2_dat_o = (rs2_addr_i == 5'd0) ? 32'd0 :
                       (we_i && rd_addr_i == rs2_addr_i) ? rd_dat_i : registers[rs2_addr_i];

endmodule

// File: rtl/cpu_pipelined.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB), fetch-to-writeback 4 cycles, never stalls.
// EX-stage operand forwarding is compiled in with CPU_PIPELINED_FWD_EN.
module cpu_pipelined
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter prog_t       PROGRAM    = default_prog()
) (
    input logic clk,
    input logic rst
);

    localparam int IMEM_WORDS = (IMEM_DEPTH < PROG_WORDS) ? IMEM_DEPTH : PROG_WORDS;
    localparam int DAW        = $clog2(DMEM_DEPTH);

    logic [31:0] pc_q;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] id_instruction;
    if_id_t      if_id_q;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0] rs1_dat, rs2_dat;
    logic [31:0] op_a, op_b_reg, op_b, alu_res;
    logic [31:0] dmem [0:DMEM_DEPTH-1];
    logic [DAW-1:0] dmem_idx;
    logic [31:0] dmem_rdat;

    assign if_pc          = pc_q;
    assign id_instruction = if_id_q.instr;

    always_comb begin
        if_instruction = NOP;
        if (pc_q[31:2] < 30'(IMEM_WORDS)) if_instruction = PROGRAM[pc_q[PROG_AW+1:2]];
    end

    cpu_pipelined_regfile regfile (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (id_instruction[19:15]),
        .rs2_addr_i (id_instruction[24:20]),
        .rs1_dat_o  (rs1_dat),
        .rs2_dat_o  (rs2_dat),
        .we_i       (mem_wb_q.reg_we),
        .rd_addr_i  (mem_wb_q.rd),
        .rd_dat_i   (mem_wb_q.wb_val)
    );

    always_comb begin
        logic [6:0] opcode;
        logic [2:0] f3;
        logic       ok;
        alu_op_t    op;
        opcode  = id_instruction[6:0];
        f3      = id_instruction[14:12];
        op      = ALU_ADD;
        ok      = 1'b0;
        id_ex_d = '0;
`ifdef CPU_PIPELINED_FWD_EN
        id_ex_d.rs1 = id_instruction[19:15];
        id_ex_d.rs2 = id_instruction[24:20];
`endif
        id_ex_d.rs1_val = rs1_dat;
        id_ex_d.rs2_val = rs2_dat;
        id_ex_d.rd      = id_instruction[11:7];
        case (opcode)
            OPC_OP: begin
                ok = decode_alu(f3, id_instruction[31:25], 1'b0, op);
                id_ex_d.alu_op = op;
                id_ex_d.reg_we = ok;
            end
            OPC_OP_IMM: begin
                ok = decode_alu(f3, id_instruction[31:25], 1'b1, op);
                id_ex_d.alu_op  = op;
                id_ex_d.use_imm = 1'b1;
                id_ex_d.imm     = {{20{id_instruction[31]}}, id_instruction[31:20]};
                id_ex_d.reg_we  = ok;
            end
            OPC_LOAD: begin
                id_ex_d.use_imm = 1'b1;
                id_ex_d.imm     = {{20{id_instruction[31]}}, id_instruction[31:20]};
                id_ex_d.reg_we  = (f3 == F3_WORD);
                id_ex_d.mem_re  = (f3 == F3_WORD);
            end
            OPC_STORE: begin
                id_ex_d.use_imm = 1'b1;
                id_ex_d.imm     = {{20{id_instruction[31]}}, id_instruction[31:25], id_instruction[11:7]};
                id_ex_d.mem_we  = (f3 == F3_WORD);
            end
            OPC_LUI: begin
                id_ex_d.alu_op  = ALU_PASS_B;
                id_ex_d.use_imm = 1'b1;
                id_ex_d.imm     = {id_instruction[31:12], 12'd0};
                id_ex_d.reg_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_a     = id_ex_q.rs1_val;
        op_b_reg = id_ex_q.rs2_val;
`ifdef CPU_PIPELINED_FWD_EN
        // Youngest producer wins: EX/MEM before MEM/WB before the register file.
        if (ex_mem_q.reg_we && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1)
            op_a = ex_mem_q.alu_res;
        else if (mem_wb_q.reg_we && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1)
            op_a = mem_wb_q.wb_val;
        if (ex_mem_q.reg_we && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2)
            op_b_reg = ex_mem_q.alu_res;
        else if (mem_wb_q.reg_we && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2)
            op_b_reg = mem_wb_q.wb_val;
`endif
        op_b = id_ex_q.use_imm ? id_ex_q.imm : op_b_reg;
        case (id_ex_q.alu_op)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
            ALU_SLL:    alu_res = op_a << op_b[4:0];
            ALU_SRL:    alu_res = op_a >> op_b[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = op_a + op_b;
        endcase
        ex_mem_d.alu_res   = alu_res;
        ex_mem_d.store_val = op_b_reg;
        ex_mem_d.rd        = id_ex_q.rd;
        ex_mem_d.reg_we    = id_ex_q.reg_we;
        ex_mem_d.mem_we    = id_ex_q.mem_we;
        ex_mem_d.mem_re    = id_ex_q.mem_re;
    end

    // Depth is a power of two, so dropping the upper word-address bits wraps addresses into range.
    assign dmem_idx  = ex_mem_q.alu_res[DAW+1:2];
    assign dmem_rdat = dmem[dmem_idx];

    always_ff @(posedge clk) begin
        if (!rst && ex_mem_q.mem_we) dmem[dmem_idx] <= ex_mem_q.store_val;
    end

    always_comb begin
        mem_wb_d.wb_val = ex_mem_q.mem_re ? dmem_rdat : ex_mem_q.alu_res;
        mem_wb_d.rd     = ex_mem_q.rd;
        mem_wb_d.reg_we = ex_mem_q.reg_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_q.instr <= NOP;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
        end else begin
            pc_q          <= pc_q + 32'd4;
            if_id_q.instr <= if_instruction;
            id_ex_q       <= id_ex_d;
            ex_mem_q      <= ex_mem_d;
            mem_wb_q      <= mem_wb_d;
        end
    end

endmodule

// File: tb/tb_cpu_pipelined.sv
// Scoreboard bench for cpu_pipelined: default program with resets, plus an ALU/memory sweep program.
module tb_cpu_pipelined;

    typedef logic [31:0][31:0] tprog_t;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_u(input int imm, input int rd);
        return {20'(imm), 5'(rd), 7'h37};
    endfunction

    function automatic tprog_t build_sweep();
        tprog_t p;
        p[0]  = enc_i(7, 0, 0, 0, 'h13);         // addi x0,x0,7
        p[1]  = enc_i(5, 0, 0, 1, 'h13);
        p[2]  = enc_i(3, 0, 0, 2, 'h13);
        p[3]  = enc_u('h80000, 5);
        p[4]  = enc_i(-1, 0, 0, 6, 'h13);
        p[5]  = enc_i(1, 0, 0, 7, 'h13);
        p[6]  = enc_r(0, 0, 0, 0, 4);             // add x4,x0,x0
        p[7]  = enc_r('h20, 1, 2, 0, 8);          // sub x8,x2,x1
        p[8]  = enc_i('h404, 5, 5, 9, 'h13);      // srai x9,x5,4
        p[9]  = enc_r(0, 6, 7, 3, 10);            // sltu x10,x7,x6
        p[10] = enc_u('h12345, 11);
        p[11] = enc_r(0, 2, 1, 7, 17);
        p[12] = enc_r(0, 2, 1, 6, 18);
        p[13] = enc_i('h678, 11, 0, 11, 'h13);
        p[14] = enc_r(0, 2, 1, 4, 19);
        p[15] = enc_r(0, 7, 6, 2, 20);            // slt x20,x6,x7
        p[16] = enc_s(8, 11, 0);                  // sw x11,8(x0)
        p[17] = enc_i(264, 0, 2, 12, 'h03);       // lw x12,264(x0) wraps to word 2
        p[18] = enc_r(0, 2, 1, 1, 21);
        p[19] = enc_r(0, 2, 5, 5, 22);
        p[20] = enc_r(0, 0, 12, 0, 13);
        p[21] = enc_i(5, 0, 0, 14, 'h13);
        p[22] = enc_i(0, 6, 2, 23, 'h13);
        p[23] = enc_i(-1, 7, 3, 24, 'h13);
        p[24] = enc_i(1, 14, 0, 15, 'h13);
        p[25] = enc_i(-1, 1, 4, 25, 'h13);
        p[26] = enc_i('hF0, 6, 7, 26, 'h13);
        p[27] = enc_r(0, 15, 14, 0, 16);
        p[28] = enc_i('h7FF, 0, 6, 27, 'h13);
        p[29] = enc_i(31, 7, 1, 28, 'h13);
        p[30] = enc_i(31, 5, 5, 29, 'h13);        // srli x29,x5,31
        p[31] = enc_r('h20, 2, 5, 5, 30);         // beyond IMEM_DEPTH=31 in dut2
        return p;
    endfunction

    function automatic tprog_t build_b2b();
        tprog_t p;
        for (int i = 0; i < 32; i++) p[i] = NOP_W;
        p[0] = enc_i(5, 0, 0, 1, 'h13);
        p[1] = enc_i(1, 1, 0, 2, 'h13);
        p[2] = enc_r(0, 2, 1, 0, 3);
        return p;
    endfunction

    localparam tprog_t SWEEP = build_sweep();
    localparam tprog_t B2B   = build_b2b();

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   tick = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    cpu_pipelined dut (.clk(clk), .rst(rst));
    cpu_pipelined #(.IMEM_DEPTH(31), .PROGRAM(SWEEP)) dut2 (.clk(clk), .rst(rst2));
`ifdef CPU_PIPELINED_FWD_EN
    cpu_pipelined #(.PROGRAM(B2B)) dut3 (.clk(clk), .rst(rst2));
`endif

    typedef struct {
        int          t;
        int          sel;
        int          idx;
        logic [31:0] val;
        string       nm;
    } exp_t;
    exp_t sb[$];
    exp_t keep_q[$];

    task automatic push(input int t, input int sel, input int idx, input logic [31:0] val, input string nm);
        exp_t e;
        e.t = t; e.sel = sel; e.idx = idx; e.val = val; e.nm = nm;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] probe(input int sel, input int idx);
        logic [4:0] ri;
        ri = 5'(idx);
        case (sel)
            0: return dut.if_pc;
            1: return dut.id_instruction;
            2: return dut.regfile.registers[ri];
            3: return dut2.regfile.registers[ri];
            5: return dut2.if_instruction;
`ifdef CPU_PIPELINED_FWD_EN
            4: return dut3.regfile.registers[ri];
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] got;
        keep_q = {};
        foreach (sb[i]) begin
            if (sb[i].t == tick) begin
                got = probe(sb[i].sel, sb[i].idx);
                checks++;
                if (got !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @tick %0d: got %h expected %h", sb[i].nm, tick, got, sb[i].val);
                end
            end else if (sb[i].t < tick) begin
                checks++;
                errors++;
                $display("FAIL %s: check slot tick %0d missed (now %0d)", sb[i].nm, sb[i].t, tick);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    initial begin
        int t0, t1, t2;
        rst = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst2 = 1'b0;
        t0 = tick;

        push(t0, 0, 0, 32'h0, "reset_if_pc");
        push(t0, 1, 0, NOP_W, "reset_id_instr");
        for (int r = 1; r <= 3; r++) push(t0, 2, r, 32'h0, $sformatf("reset_x%0d", r));
        for (int k = 1; k < 8; k++) push(t0 + k, 0, 0, 32'(4 * k), $sformatf("if_pc_cycle%0d", k));
        push(t0 + 1, 1, 0, 32'h0050_0093, "id_instr_cycle1");
        push(t0 + 2, 1, 0, NOP_W, "id_instr_cycle2");
        push(t0 + 5, 1, 0, 32'h0030_0113, "id_instr_cycle5");
        push(t0 + 9, 1, 0, 32'h0020_81B3, "id_instr_cycle9");
        push(t0 + 4, 2, 1, 32'h0, "x1_before_wb");
        push(t0 + 5, 2, 1, 32'h5, "x1_after_wb");
        push(t0 + 12, 2, 3, 32'h0, "x3_before_wb");
        push(t0 + 13, 2, 3, 32'h8, "x3_after_wb");
        push(t0 + 25, 2, 1, 32'h5, "run1_x1");
        push(t0 + 25, 2, 2, 32'h3, "run1_x2");
        push(t0 + 25, 2, 3, 32'h8, "run1_x3");

        push(t0 + 5, 3, 1, 32'h0, "sw_x1_before_wb");
        push(t0 + 6, 3, 1, 32'h5, "sw_x1_after_wb");
        push(t0 + 30, 5, 0, 32'h01F2_DE93, "rom_last_word");
        push(t0 + 31, 5, 0, NOP_W, "rom_out_of_range");
        push(t0 + 40, 3, 0, 32'h0, "x0_addi");
        push(t0 + 40, 3, 4, 32'h0, "add_x0_x0");
        push(t0 + 40, 3, 8, 32'hFFFF_FFFE, "sub");
        push(t0 + 40, 3, 9, 32'hF800_0000, "srai");
        push(t0 + 40, 3, 10, 32'h1, "sltu");
        push(t0 + 40, 3, 11, 32'h1234_5678, "lui_addi");
        push(t0 + 40, 3, 12, 32'h1234_5678, "lw_after_sw");
        push(t0 + 40, 3, 13, 32'h1234_5678, "use_load");
        push(t0 + 40, 3, 16, 32'd11, "spaced_dep");
        push(t0 + 40, 3, 17, 32'h1, "and");
        push(t0 + 40, 3, 18, 32'h7, "or");
        push(t0 + 40, 3, 19, 32'h6, "xor");
        push(t0 + 40, 3, 20, 32'h1, "slt");
        push(t0 + 40, 3, 21, 32'h28, "sll");
        push(t0 + 40, 3, 22, 32'h1000_0000, "srl");
        push(t0 + 40, 3, 23, 32'h1, "slti");
        push(t0 + 40, 3, 24, 32'h1, "sltiu");
        push(t0 + 40, 3, 25, 32'hFFFF_FFFA, "xori");
        push(t0 + 40, 3, 26, 32'hF0, "andi");
        push(t0 + 40, 3, 27, 32'h7FF, "ori");
        push(t0 + 40, 3, 28, 32'h8000_0000, "slli");
        push(t0 + 40, 3, 29, 32'h1, "srli");
        push(t0 + 40, 3, 30, 32'h0, "not_fetched");
`ifdef CPU_PIPELINED_FWD_EN
        push(t0 + 15, 4, 2, 32'd6, "fwd_x2");
        push(t0 + 15, 4, 3, 32'd11, "fwd_x3");
`endif

        repeat (26) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t1 = tick;
        push(t1, 0, 0, 32'h0, "rerun_if_pc");
        push(t1, 2, 3, 32'h0, "rerun_x3_cleared");
        push(t1 + 9, 2, 1, 32'h5, "rerun_x1_cycle9");
        push(t1 + 9, 2, 2, 32'h3, "rerun_x2_cycle9");
        push(t1 + 10, 2, 3, 32'h0, "rerun_x3_cycle10");

        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t2 = tick;
        push(t2, 0, 0, 32'h0, "midrst_if_pc");
        push(t2, 1, 0, NOP_W, "midrst_id_instr");
        for (int r = 0; r < 32; r++) push(t2, 2, r, 32'h0, $sformatf("midrst_x%0d", r));
        push(t2 + 1, 0, 0, 32'h4, "midrst_if_pc_next");
        push(t2 + 25, 2, 1, 32'h5, "final_x1");
        push(t2 + 25, 2, 2, 32'h3, "final_x2");
        push(t2 + 25, 2, 3, 32'h8, "final_x3");

        for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
        #1;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never checked, expected %h at tick %0d", sb[i].nm, sb[i].val, sb[i].t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_pipelined.md
Name: cpu_pipelined

Overview:
- Five-stage in-order RV32I-subset core: IF, ID, EX, MEM, WB.
- Instruction ROM and data RAM are internal; the only ports are clock and reset.
- No hazard detection and no branches. Programs space dependent instructions with NOPs unless forwarding is compiled in.
- Top-level CPU of the riscv-cpu design. Benches observe it hierarchically.

Parameters:
- IMEM_DEPTH, 64, instruction ROM depth in 32-bit words.
- DMEM_DEPTH, 64, data RAM depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Hierarchical names are required for verification:
  - if_pc [31:0]: IF-stage PC.
  - if_instruction [31:0]: ROM word at if_pc.
  - id_instruction [31:0]: IF/ID pipeline register.
  - Register file instance named regfile, holding array registers[0:31] of 32-bit values.
- Reset (rst=1 at clk rise):
  - if_pc <= RESET_PC.
  - All pipeline registers hold a NOP (32'h00000013) with control bits cleared (no register write, no memory write).
  - All 32 registers <= 0.
  - Data RAM is not cleared.
  - Reset asserted mid-run has the same effect.
- IF:
  - if_instruction is combinational: ROM[if_pc[31:2]].
  - Addresses at or beyond IMEM_DEPTH return NOP.
  - if_pc <= if_pc + 4 every non-reset cycle.
- ROM default contents, word index: value:
  - 0: 00500093 (addi x1,x0,5)
  - 1-3: NOP
  - 4: 00300113 (addi x2,x0,3)
  - 5-7: NOP
  - 8: 002081B3 (add x3,x1,x2)
  - all remaining words: NOP
- ID:
  - Decode, then read rs1/rs2 asynchronously.
  - Generate the immediate (I-type and S-type, sign-extended).
  - Register file is write-through: a WB write to the same register in the same cycle is returned by the read.
  - x0 always reads 0; writes to x0 are ignored.
- EX, supported operations:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - LUI.
  - Arithmetic wraps modulo 2^32; shift amount is [4:0].
- MEM:
  - LW reads DMEM[addr[31:2]] combinationally.
  - SW writes on the clock edge.
  - Word access only; low address bits are ignored; out-of-range addresses are masked to the depth.
- WB:
  - Writes the ALU result or load data to rd on the clock edge when the write flag is set.
- Unknown opcodes execute as NOP (no writes).
- Latency: an instruction fetched at cycle n writes back at the edge ending cycle n+4.
- Without forwarding: a consumer must be at least 3 instructions after its producer (relies on the write-through read).

Optional Feature:
- Macro: CPU_PIPELINED_FWD_EN.
- Defined: EX-stage forwarding of rs1/rs2 operands.
  - Priority: EX/MEM result over MEM/WB result over register-file value.
  - Never forward for rd=x0.
  - Forward only when the producer writes a register.
  - Load-use hazards are still not handled.
- Undefined: no forwarding muxes. Correctness requires the 3-instruction spacing.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, LUI);
  - funct3/funct7 constants;
  - ALU-op enum;
  - NOP constant 32'h00000013;
  - pipeline-register structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t).
- One sub-module: regfile (2 async read ports, 1 sync write port, write-through, x0 hardwired to 0), instantiated as regfile.
- ALU and memories stay inline.

Test Plan:
- Reset: hold rst 3 cycles -> if_pc=0, id_instruction=00000013, registers[1..3]=0.
- Default program, 25 cycles after reset release:
  - registers[1]=5, registers[2]=3, registers[3]=8.
  - if_pc advances by 4 each cycle from 0.
- Pipeline trace: id_instruction equals the prior cycle's if_instruction; 00500093 appears in id_instruction in the 2nd cycle after reset.
- x0 protection: ROM addi x0,x0,7 -> registers[0] stays 0; a later add x4,x0,x0 yields 0.
- ALU/memory sweep:
  - SUB 3-5 -> FFFFFFFE.
  - SRA of 80000000 by 4 -> F8000000.
  - SLTU 1<FFFFFFFF -> 1.
  - SW then LW of 12345678 -> same value read back.
- Mid-run reset at cycle 10 -> next cycle if_pc=0 and all registers 0; the program reruns to the same final values.
- With CPU_PIPELINED_FWD_EN: back-to-back addi x1,x0,5; addi x2,x1,1; add x3,x1,x2 with no NOPs -> x3=11. Without the macro, a run with the required spacing still gives x3=11.
